stream_max_min: RTL
===================

# stream_max_min

Sequential streaming counterpart of the combinational max/min comparator in the vector_abs lab. It consumes vector elements one per handshake and reports the largest and smallest element of the frame once the last element arrives, plus the element count. A downstream magnitude/abs stage sits after it and consumes the result through a valid/ready handshake.

## Interface
- WIDTH, 32, element width in bits
- CNT_W, 16, element counter width
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- data_i  input  WIDTH  element value
- valid_i  input  1  element present on data_i
- last_i  input  1  element on data_i is the last of the frame; qualified by valid_i
- ready_o  output  1  block accepts an element this cycle
- max_o  output  WIDTH  frame maximum
- min_o  output  WIDTH  frame minimum
- count_o  output  CNT_W  number of elements in the frame, saturating
- res_valid_o  output  1  max_o/min_o/count_o hold a completed frame result
- res_ready_i  input  1  downstream takes the result this cycle

## Operation
- Input transfer (beat) when valid_i && ready_o on a rising edge; result transfer when res_valid_o && res_ready_i.
- FSM states: EMPTY, ACCUM, RESULT. Reset state EMPTY.
- EMPTY: ready_o=1, res_valid_o=0. On beat: max=min=data_i, count=1; last_i=1 -> RESULT, else -> ACCUM.
- ACCUM: ready_o=1, res_valid_o=0. On beat: max=data_i if data_i>max; min=data_i if data_i<min; count+1 (saturate at 2^CNT_W-1, no wrap); last_i=1 -> RESULT, else stay.
- RESULT: ready_o=0, res_valid_o=1, max_o/min_o/count_o stable. On result transfer -> EMPTY. Input beats impossible (ready_o=0); valid_i ignored.
- Equal values: no update (ties keep the held value; outcome identical).
- ready_o is a function of state only; no combinational path from valid_i or res_ready_i to any output.
- max_o/min_o/count_o are the accumulation registers, visible in all states; meaningful only while res_valid_o=1.
- last_i without valid_i: ignored.

## Timing
- Reset: state EMPTY, max_o=0, min_o=0, count_o=0, res_valid_o=0, ready_o=1 in the cycle after rst_i sampled high.
- rst_i wins over any simultaneous beat or result transfer; a partial frame or pending result is discarded.
- Latency: res_valid_o rises in the cycle after the last beat is accepted; single-element frame likewise 1 cycle.
- Throughput: one element per cycle inside a frame; one dead input cycle per frame minimum (the RESULT cycle), more if res_ready_i is held low.
- res_valid_o stays high and outputs stay stable until res_ready_i; first input beat of the next frame accepted the cycle after the result transfer.

## Configuration
- STREAM_MAX_MIN_SIGNED_EN defined: data_i treated as two's complement; comparisons signed.
- Not defined: comparisons unsigned. All other behaviour identical.

## Test plan
- Reset then frame 5, 17, 3, 9 (last on 9), res_ready_i=1 -> res_valid_o one cycle after 9 accepted, max_o=17, min_o=3, count_o=4, returns to ready_o=1 next cycle.
- Single-element frame 0xDEADBEEF with last_i -> max_o=min_o=0xDEADBEEF, count_o=1; hold res_ready_i=0 for 5 cycles -> ready_o=0, outputs stable throughout.
- Values 0xFFFFFFFF, 0x00000001 -> without macro max_o=0xFFFFFFFF, min_o=1; with STREAM_MAX_MIN_SIGNED_EN max_o=1, min_o=0xFFFFFFFF.
- Random valid_i gaps within a 10-element frame 10..1 -> only accepted beats counted, max_o=10, min_o=1, count_o=10.
- rst_i asserted after 3 beats of a frame -> all outputs reset values; new frame 7, 2 (last) -> max_o=7, min_o=2, count_o=2, no residue from aborted frame.
- CNT_W=2, frame of 6 equal values 4 -> count_o=3 (saturated), max_o=min_o=4.

Source files
------------

// File: rtl/stream_max_min.sv
// Streaming frame max/min/count tracker with a valid/ready result port.
// Define STREAM_MAX_MIN_SIGNED_EN to compare elements as two's complement.
module stream_max_min #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             last_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o,
    output logic [CNT_W-1:0] count_o,
    output logic             res_valid_o,
    input  logic             res_ready_i
);

    typedef enum logic [1:0] {EMPTY, ACCUM, RESULT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [WIDTH-1:0]   min_q, min_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               res_valid_q, res_valid_d;

    logic beat;
    logic gt_max;
    logic lt_min;

    assign beat = valid_i && ready_q;

`ifdef STREAM_MAX_MIN_SIGNED_EN
    assign gt_max = $signed(data_i) > $signed(max_q);
    assign lt_min = $signed(data_i) < $signed(min_q);
`else
    assign gt_max = data_i > max_q;
    assign lt_min = data_i < min_q;
`endif

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        count_d = count_q;
        case (state_q)
            EMPTY: begin
                if (beat) begin
                    max_d   = data_i;
                    min_d   = data_i;
                    count_d = CNT_W'(1);
                    state_d = last_i ? RESULT : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (gt_max) max_d = data_i;
                    if (lt_min) min_d = data_i;
                    // Saturate rather than wrap so oversized frames report the ceiling.
                    if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
                    if (last_i) state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_valid_q && res_ready_i) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        ready_d     = (state_d != RESULT);
        res_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            max_q       <= '0;
            min_q       <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            min_q       <= min_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign ready_o     = ready_q;
    assign res_valid_o = res_valid_q;
    assign max_o       = max_q;
    assign min_o       = min_q;
    assign count_o     = count_q;

endmodule
